// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: RAW scoreboard and stall/bubble/flush/freeze sequencing for the ID/EX register
module id_ex_hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rd_we,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH, FROZEN} state_t;
  state_t state_q, next_state;
  logic [DEPTH-1:0] sb_v;
  logic [4:0] sb_a [DEPTH];
  logic h1, h2, hazard, push_v;
  always_comb begin
    h1 = 1'b0;
    h2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      h1 = h1 | (sb_v[i] && sb_a[i] == id_rs1_addr);
      h2 = h2 | (sb_v[i] && sb_a[i] == id_rs2_addr);
    end
  end
  assign hazard = id_valid & ((id_rs1_used & |id_rs1_addr & h1) | (id_rs2_used & |id_rs2_addr & h2));
  always_comb begin
    next_state   = mem_busy ? FROZEN : ex_branch_taken ? FLUSH : hazard ? STALL : RUN;
    stall_if_id  = !reset && next_state == STALL;
    flush_if_id  = !reset && next_state == FLUSH;
    freeze       = !reset && next_state == FROZEN;
    bubble_id_ex = reset || next_state == STALL || next_state == FLUSH;
    push_v       = next_state == RUN && id_valid && id_rd_we && |id_rd_addr;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else state_q <= next_state;
  end
  // WB slot is still checked: the register file does not forward its write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_v <= '0;
      for (int i = 0; i < DEPTH; i++) sb_a[i] <= '0;
      stall_count <= '0;
    end else if (!mem_busy) begin
      sb_v <= {sb_v[DEPTH-2:0], push_v};
      for (int i = DEPTH - 1; i > 0; i--) sb_a[i] <= sb_a[i-1];
      sb_a[0] <= id_rd_addr;
      if (next_state == STALL && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
  assign state = state_q;
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb_id_ex_hazard_ctrl: table-driven cycle vectors plus reset and saturation sequences
module tb_id_ex_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_rd_we = 0;
  logic [4:0] id_rs1_addr = 0, id_rs2_addr = 0, id_rd_addr = 0;
  logic ex_branch_taken = 0, mem_busy = 0;
  logic stall_if_id, bubble_id_ex, flush_if_id, freeze;
  logic [1:0] state;
  logic [15:0] stall_count;
  logic s_stall, s_bubble, s_flush, s_freeze;
  logic [1:0] s_state;
  logic [1:0] s_count;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  id_ex_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .freeze(freeze), .state(state), .stall_count(stall_count)
  );

  id_ex_hazard_ctrl #(.DEPTH(3), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_if_id(s_stall), .bubble_id_ex(s_bubble), .flush_if_id(s_flush),
    .freeze(s_freeze), .state(s_state), .stall_count(s_count)
  );

  typedef struct {
    int v, rs1, u1, rs2, u2, rd, we, br, mb;
    int st, bb, fl, fz, state, cnt;
  } vec_t;
  vec_t tbl[28];

  function automatic vec_t mk(int v, int rs1, int u1, int rs2, int u2, int rd, int we, int br, int mb,
                              int st, int bb, int fl, int fz, int sta, int cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd; r.we = we; r.br = br; r.mb = mb;
    r.st = st; r.bb = bb; r.fl = fl; r.fz = fz; r.state = sta; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    id_valid = t.v[0]; id_rs1_addr = t.rs1[4:0]; id_rs1_used = t.u1[0];
    id_rs2_addr = t.rs2[4:0]; id_rs2_used = t.u2[0];
    id_rd_addr = t.rd[4:0]; id_rd_we = t.we[0];
    ex_branch_taken = t.br[0]; mem_busy = t.mb[0];
  endtask

  task automatic chk_all(string tag, int st, int bb, int fl, int fz, int sta, int cnt);
    chk({tag, " stall"}, int'(stall_if_id), st);
    chk({tag, " bubble"}, int'(bubble_id_ex), bb);
    chk({tag, " flush"}, int'(flush_if_id), fl);
    chk({tag, " freeze"}, int'(freeze), fz);
    chk({tag, " state"}, int'(state), sta);
    chk({tag, " count"}, int'(stall_count), cnt);
  endtask

  initial begin
    // cycle vectors: v rs1 u1 rs2 u2 rd we br mb | stall bubble flush freeze state count
    tbl[0]  = mk(1,1,1,2,1,5,1,0,0, 0,0,0,0,0,0);
    tbl[1]  = mk(1,5,1,0,0,6,1,0,0, 1,1,0,0,0,0);
    tbl[2]  = mk(1,5,1,0,0,6,1,0,0, 1,1,0,0,1,1);
    tbl[3]  = mk(1,5,1,0,0,6,1,0,0, 1,1,0,0,1,2);
    tbl[4]  = mk(1,5,1,0,0,6,1,0,0, 0,0,0,0,1,3);
    tbl[5]  = mk(1,0,0,0,0,0,1,0,0, 0,0,0,0,0,3);
    tbl[6]  = mk(1,0,1,0,0,0,0,0,0, 0,0,0,0,0,3);
    tbl[7]  = mk(1,0,0,0,0,9,0,0,0, 0,0,0,0,0,3);
    tbl[8]  = mk(1,0,0,9,1,7,1,0,0, 0,0,0,0,0,3);
    tbl[9]  = mk(1,1,1,0,0,10,0,0,0, 0,0,0,0,0,3);
    tbl[10] = mk(1,0,0,7,1,0,0,0,0, 1,1,0,0,0,3);
    tbl[11] = mk(1,0,0,7,1,0,0,0,0, 1,1,0,0,1,4);
    tbl[12] = mk(1,0,0,7,1,0,0,0,0, 0,0,0,0,1,5);
    tbl[13] = mk(1,0,0,0,0,3,1,0,0, 0,0,0,0,0,5);
    tbl[14] = mk(1,3,1,0,0,0,0,0,0, 1,1,0,0,0,5);
    tbl[15] = mk(1,3,1,0,0,0,0,1,0, 0,1,1,0,1,6);
    tbl[16] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,2,6);
    tbl[17] = mk(1,0,0,0,0,4,1,0,0, 0,0,0,0,0,6);
    tbl[18] = mk(1,4,1,0,0,0,0,0,0, 1,1,0,0,0,6);
    tbl[19] = mk(1,4,1,0,0,0,0,0,1, 0,0,0,1,1,7);
    for (int i = 20; i < 24; i++) tbl[i] = mk(1,4,1,0,0,0,0,0,1, 0,0,0,1,3,7);
    tbl[24] = mk(1,4,1,0,0,0,0,0,0, 1,1,0,0,3,7);
    tbl[25] = mk(1,4,1,0,0,0,0,0,0, 1,1,0,0,1,8);
    tbl[26] = mk(1,4,1,0,0,0,0,0,0, 0,0,0,0,1,9);
    tbl[27] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,9);

    #1 chk_all("reset", 0, 1, 0, 0, 0, 0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2 chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].bb, tbl[i].fl, tbl[i].fz, tbl[i].state, tbl[i].cnt);
    end
    chk("sat count", int'(s_count), 3);

    // async reset in the middle of a stall
    @(negedge clk) drive(mk(1,0,0,0,0,5,1,0,0, 0,0,0,0,0,0));
    @(negedge clk) drive(mk(1,5,1,0,0,0,0,0,0, 0,0,0,0,0,0));
    #2 chk("mid stall", int'(stall_if_id), 1);
    #1 reset = 1;
    #1 chk_all("async rst", 0, 1, 0, 0, 0, 0);
    @(negedge clk) reset = 0;
    #2 chk_all("post rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk) drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    #2 chk("post rst state", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
